bin_bcd_conv_seq: RTL and testbench
===================================

Name: bin_bcd_conv_seq

Overview:
Sequential, parameterised bidirectional converter: binary→BCD (double dabble) or BCD→binary (reverse double dabble), selected per transaction. Successor to the unrolled digit-cell converter: one shared shift/adjust datapath iterated over cycles instead of an N×N cell array. Adds valid/ready handshakes on both sides, overflow and invalid-digit detection, and a saturating result. Sits between the binary datapath and the display/decimal I/O path.

Parameters:
BIN_W, 10, binary operand/result width (≥1)
NUM_DIGITS, 4, number of BCD digits (≥1); each digit 4 bits; index 0 = units digit

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  converter can accept
in_mode  in  1  0 = bin→BCD, 1 = BCD→bin
in_bin  in  BIN_W  binary operand (mode 0)
in_bcd  in  [NUM_DIGITS-1:0][3:0]  BCD operand (mode 1)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_mode  out  1  mode of current result
out_bin  out  BIN_W  binary result (mode 1)
out_bcd  out  [NUM_DIGITS-1:0][3:0]  BCD result (mode 0)
out_err  out  1  overflow or invalid BCD digit
busy  out  1  state ≠ IDLE

Behaviour:
- FSM: IDLE, SHIFT, DONE. in_ready = (state==IDLE), combinational. busy = !IDLE.
- rst low: state=IDLE; out_valid, out_mode, out_bin, out_bcd, out_err, iteration counter, working registers = 0. Inputs are ignored while rst is low, even though in_ready reads 1.
- Accept on edge with in_valid && in_ready: capture operand and mode, clear the sticky error, counter=0, go to SHIFT.
- Mode 0: working reg {bcd[4·NUM_DIGITS], bin[BIN_W]}. Per SHIFT cycle, each digit ≥5 gets +3, then the whole reg shifts left 1. Any 1 shifted out of the top digit sets sticky overflow. Run BIN_W iterations.
- Mode 1: working reg {bcd, bin[4·NUM_DIGITS]}. Per SHIFT cycle, shift right 1, then each digit ≥8 gets −3. Run 4·NUM_DIGITS iterations. Overflow if any result bit above BIN_W−1 is 1.
- Mode 1 invalid digit: any input digit >9 at accept → skip SHIFT, go straight to DONE with err=1.
- Latency (accept edge → first cycle out_valid=1): mode 0 = BIN_W cycles; mode 1 = 4·NUM_DIGITS cycles; invalid digit = 1 cycle.
- Last iteration: result registers are loaded and state goes to DONE on the same edge.
- Saturation when out_err=1: mode 0 → out_bcd all digits 9; mode 1 → out_bin all ones.
- The unused result port of the current mode is driven 0.
- DONE: out_valid=1. Outputs stay stable while out_valid && !out_ready.
- On out_valid && out_ready: out_valid→0, state→IDLE. in_ready rises the next cycle; no same-cycle re-accept.
- Data outputs keep their last values after the handshake; only out_valid drops.
- rst asserted mid-SHIFT or in DONE: transaction aborted, reset values applied immediately (asynchronous).
- in_mode, in_bin and in_bcd changes outside the accept edge have no effect.

Decomposition:
- Package bin_bcd_pkg: state enum (IDLE/SHIFT/DONE); mode constants MODE_B2D=0, MODE_D2B=1; BCD_W=4; localparam helper for counter width = $clog2(max(BIN_W, 4·NUM_DIGITS)+1).
- Sub-module bcd_digit_adj: combinational 4-bit cell. Input dir: +3 if ≥5 (dir 0), −3 if ≥8 (dir 1). Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Mode 0, in_bin=999, out_ready=1 → out_bcd digits {0,9,9,9}, err=0; out_valid exactly 10 cycles after accept, high for one cycle.
- Mode 0, NUM_DIGITS=3 instance: in_bin=1000 → err=1, out_bcd {9,9,9}. Same instance, in_bin=0 → {0,0,0}, err=0.
- Mode 1, in_bcd {0,5,1,2} → out_bin=512, err=0, latency 16. Mode 1, {1,0,2,4} → err=1, out_bin=1023.
- Mode 1, in_bcd {0,0,A,1} → err=1, out_bin=1023, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → all outputs stable, in_ready=0; raise out_ready → out_valid=0 next cycle, in_ready=1; a new request is accepted on that cycle.
- Reset mid-SHIFT (mode 0, 4th iteration of in_bin=1023) → all outputs 0 immediately. After release, convert 37 → {0,0,3,7}, err=0, 10-cycle latency.

Source files
------------

// File: rtl/bin_bcd_pkg.sv
// Shared types, constants and sizing helpers for the sequential binary/BCD converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_B2D = 1'b0;
  localparam logic MODE_D2B = 1'b1;

  localparam int unsigned BCD_W = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the larger of the two iteration counts.
  function automatic int unsigned cnt_width(input int unsigned bin_w, input int unsigned num_digits);
    return $clog2(max_u(bin_w, BCD_W * num_digits) + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction cell: +3 when >=5 (dir 0), -3 when >=8 (dir 1).
module bcd_digit_adj (
  input  logic       dir,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional digit correction for double dabble / reverse double dabble
  always_comb begin
    dout = din;
    if (!dir && (din >= 4'd5)) begin
      dout = din + 4'd3;
    end else if (dir && (din >= 4'd8)) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bin_bcd_conv_seq.sv
// Sequential bidirectional binary<->BCD converter with valid/ready handshakes,
// overflow / invalid-digit detection and saturating results.
module bin_bcd_conv_seq
  import bin_bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_mode,
  input  logic [BIN_W-1:0]                    in_bin,
  input  logic [NUM_DIGITS-1:0][BCD_W-1:0]    in_bcd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_mode,
  output logic [BIN_W-1:0]                    out_bin,
  output logic [NUM_DIGITS-1:0][BCD_W-1:0]    out_bcd,
  output logic                                out_err,
  output logic                                busy
);

  localparam int unsigned DW    = BCD_W * NUM_DIGITS;
  localparam int unsigned WB    = max_u(BIN_W, DW);
  localparam int unsigned CNT_W = cnt_width(BIN_W, NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_B2D = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] LAST_D2B = CNT_W'(DW - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      bcd_q, bcd_d;
  logic [WB-1:0]      bin_q, bin_d;
  logic               out_valid_q, out_valid_d;
  logic               out_mode_q, out_mode_d;
  logic               out_err_q, out_err_d;
  logic [BIN_W-1:0]   out_bin_q, out_bin_d;
  logic [DW-1:0]      out_bcd_q, out_bcd_d;

  logic               src_mode, src_err;
  logic [DW-1:0]      src_bcd;
  logic [WB-1:0]      src_bin;
  logic [CNT_W-1:0]   src_idx;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] adj_in, adj_out;
  logic [DW-1:0]      adj_flat;

  logic [DW-1:0]      it_bcd;
  logic [WB-1:0]      it_bin;
  logic               it_err, it_last;
  logic [WB-1:0]      d2b_ext;

  logic               res_err;
  logic [BIN_W-1:0]   res_bin;
  logic [DW-1:0]      res_bcd;
  logic [DW-1:0]      nines;
  logic               digit_bad;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;
  assign out_bin   = out_bin_q;
  assign out_bcd   = out_bcd_q;

  // The accept edge performs the first iteration straight from the inputs,
  // so the datapath source is the ports in IDLE and the working regs otherwise.
  always_comb begin
    src_mode = mode_q;
    src_err  = err_q;
    src_bcd  = bcd_q;
    src_bin  = bin_q;
    src_idx  = cnt_q + CNT_W'(1);
    if (state_q == IDLE) begin
      src_mode = in_mode;
      src_err  = 1'b0;
      src_idx  = '0;
      src_bin  = '0;
      src_bcd  = '0;
      if (in_mode == MODE_D2B) begin
        src_bcd = in_bcd;
      end else begin
        src_bin[WB-1 -: BIN_W] = in_bin;
      end
    end
  end

  // Digit cells see the raw digits (bin->BCD) or the right-shifted digits (BCD->bin)
  always_comb begin
    adj_in = (src_mode == MODE_D2B) ? {1'b0, src_bcd[DW-1:1]} : src_bcd;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dir  (src_mode),
      .din  (adj_in[g]),
      .dout (adj_out[g])
    );
  end

  assign adj_flat = adj_out;

  // One shift/adjust iteration of the working register
  always_comb begin
    it_bcd  = '0;
    it_bin  = '0;
    it_err  = src_err;
    it_last = 1'b0;
    if (src_mode == MODE_B2D) begin
      it_bcd  = {adj_flat[DW-2:0], src_bin[WB-1]};
      it_bin  = {src_bin[WB-2:0], 1'b0};
      it_err  = src_err | adj_flat[DW-1];
      it_last = (src_idx == LAST_B2D);
    end else begin
      it_bcd  = adj_flat;
      it_bin  = {src_bcd[0], src_bin[WB-1:1]};
      it_last = (src_idx == LAST_D2B);
    end
    d2b_ext = WB'(it_bin[WB-1 -: DW]);
  end

  // Final result with saturation; the other mode's result port reads zero
  always_comb begin
    nines = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nines[i*BCD_W +: BCD_W] = 4'd9;
    end
    res_err = 1'b0;
    res_bin = '0;
    res_bcd = '0;
    if (src_mode == MODE_B2D) begin
      res_err = it_err;
      res_bcd = it_err ? nines : it_bcd;
    end else begin
      res_err = |(d2b_ext >> BIN_W);
      res_bin = res_err ? '1 : d2b_ext[BIN_W-1:0];
    end
  end

  // Any BCD input digit above 9
  always_comb begin
    digit_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (in_bcd[i] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end

  // Next-state, working register and output register updates
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    out_bin_d   = out_bin_q;
    out_bcd_d   = out_bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = in_mode;
          cnt_d  = '0;
          if ((in_mode == MODE_D2B) && digit_bad) begin
            bcd_d       = in_bcd;
            bin_d       = '0;
            err_d       = 1'b1;
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_mode_d  = MODE_D2B;
            out_err_d   = 1'b1;
            out_bin_d   = '1;
            out_bcd_d   = '0;
          end else begin
            bcd_d = it_bcd;
            bin_d = it_bin;
            err_d = it_err;
            if (it_last) begin
              state_d     = DONE;
              err_d       = res_err;
              out_valid_d = 1'b1;
              out_mode_d  = src_mode;
              out_err_d   = res_err;
              out_bin_d   = res_bin;
              out_bcd_d   = res_bcd;
            end else begin
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        bcd_d = it_bcd;
        bin_d = it_bin;
        err_d = it_err;
        cnt_d = cnt_q + CNT_W'(1);
        if (it_last) begin
          state_d     = DONE;
          err_d       = res_err;
          out_valid_d = 1'b1;
          out_mode_d  = src_mode;
          out_err_d   = res_err;
          out_bin_d   = res_bin;
          out_bcd_d   = res_bcd;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_bin_q   <= '0;
      out_bcd_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
      out_bin_q   <= out_bin_d;
      out_bcd_q   <= out_bcd_d;
    end
  end

endmodule

// File: tb/tb_bin_bcd_conv_seq.sv
// Directed, table-driven bench for bin_bcd_conv_seq (default and 3-digit instances).
module tb_bin_bcd_conv_seq;

  logic clk;
  logic rst;

  // Default instance: BIN_W=10, NUM_DIGITS=4
  logic             in_valid, in_ready, in_mode;
  logic [9:0]       in_bin;
  logic [3:0][3:0]  in_bcd;
  logic             out_valid, out_ready, out_mode, out_err, busy;
  logic [9:0]       out_bin;
  logic [3:0][3:0]  out_bcd;

  // Three-digit instance
  logic             v3, rdy3, mode3, ov3, ordy3, omode3, oerr3, busy3;
  logic [9:0]       bin3, obin3;
  logic [2:0][3:0]  bcd3, obcd3;

  int n_vec;
  int n_err;

  typedef struct {
    logic        mode;
    logic [9:0]  bin;
    logic [15:0] bcd;
    logic [9:0]  exp_bin;
    logic [15:0] exp_bcd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  bin_bcd_conv_seq #(.BIN_W(10), .NUM_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_bin    (in_bin),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_bin   (out_bin),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .busy      (busy)
  );

  bin_bcd_conv_seq #(.BIN_W(10), .NUM_DIGITS(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v3),
    .in_ready  (rdy3),
    .in_mode   (mode3),
    .in_bin    (bin3),
    .in_bcd    (bcd3),
    .out_valid (ov3),
    .out_ready (ordy3),
    .out_mode  (omode3),
    .out_bin   (obin3),
    .out_bcd   (obcd3),
    .out_err   (oerr3),
    .busy      (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles from the accept edge until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_main(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = v.mode;
    in_bin   = v.bin;
    in_bcd   = v.bcd;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = ~v.mode;
    in_bin   = 10'($urandom);
    in_bcd   = 16'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_valid(lat);
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("out_bin", 32'(out_bin), 32'(v.exp_bin));
    check("out_bcd", 32'(out_bcd), 32'(v.exp_bcd));
    check("out_err", 32'(out_err), 32'(v.exp_err));
    check("out_mode", 32'(out_mode), 32'(v.mode));
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(out_valid), 32'd0);
    check("bin_hold_after_hs", 32'(out_bin), 32'(v.exp_bin));
    check("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic run3(input logic [9:0] b, input logic [11:0] exp_bcd, input logic exp_err);
    int lat;
    @(negedge clk);
    v3    = 1'b1;
    mode3 = 1'b0;
    bin3  = b;
    bcd3  = '0;
    @(posedge clk); #1;
    v3   = 1'b0;
    bin3 = 10'($urandom);
    lat  = 1;
    while (!ov3 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("d3_latency", 32'(lat), 32'd10);
    check("d3_out_bcd", 32'(obcd3), 32'(exp_bcd));
    check("d3_out_err", 32'(oerr3), 32'(exp_err));
    check("d3_out_bin_unused", 32'(obin3), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;

    //        mode  bin      bcd       exp_bin  exp_bcd   err  lat
    vecs[0]  = '{1'b0, 10'd999,  16'h0000, 10'd0,    16'h0999, 1'b0, 10};
    vecs[1]  = '{1'b0, 10'd0,    16'h0000, 10'd0,    16'h0000, 1'b0, 10};
    vecs[2]  = '{1'b0, 10'd1023, 16'h0000, 10'd0,    16'h1023, 1'b0, 10};
    vecs[3]  = '{1'b0, 10'd37,   16'h0000, 10'd0,    16'h0037, 1'b0, 10};
    vecs[4]  = '{1'b0, 10'd512,  16'h0000, 10'd0,    16'h0512, 1'b0, 10};
    vecs[5]  = '{1'b0, 10'd1,    16'h0000, 10'd0,    16'h0001, 1'b0, 10};
    vecs[6]  = '{1'b1, 10'd0,    16'h0512, 10'd512,  16'h0000, 1'b0, 16};
    vecs[7]  = '{1'b1, 10'd0,    16'h1024, 10'd1023, 16'h0000, 1'b1, 16};
    vecs[8]  = '{1'b1, 10'd0,    16'h1023, 10'd1023, 16'h0000, 1'b0, 16};
    vecs[9]  = '{1'b1, 10'd0,    16'h9999, 10'd1023, 16'h0000, 1'b1, 16};
    vecs[10] = '{1'b1, 10'd0,    16'h0000, 10'd0,    16'h0000, 1'b0, 16};
    vecs[11] = '{1'b1, 10'd0,    16'h00A1, 10'd1023, 16'h0000, 1'b1, 1};
    vecs[12] = '{1'b1, 10'd0,    16'hF000, 10'd1023, 16'h0000, 1'b1, 1};
    vecs[13] = '{1'b1, 10'd0,    16'h0999, 10'd999,  16'h0000, 1'b0, 16};

    // Reset with a request held: it must be ignored
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_bin    = 10'd5;
    in_bcd    = '0;
    out_ready = 1'b1;
    v3        = 1'b0;
    mode3     = 1'b0;
    bin3      = '0;
    bcd3      = '0;
    ordy3     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin", 32'(out_bin), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_main(vecs[i]);
    end

    // Three-digit instance: overflow saturation and zero
    run3(10'd1000, 12'h999, 1'b1);
    run3(10'd0,    12'h000, 1'b0);
    run3(10'd999,  12'h999, 1'b0);

    // Backpressure: result held for 5 cycles, then release with a new request waiting
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_bin   = 10'd123;
    in_bcd   = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd10);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_bcd", 32'(out_bcd), 32'h0123);
      check("bp_out_err", 32'(out_err), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_bcd    = 16'h0042;
    in_bin    = 10'd7;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    check("bp_bcd_hold", 32'(out_bcd), 32'h0123);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accept", 32'(busy), 32'd1);
    wait_valid(lat);
    check("bp2_latency", 32'(lat), 32'd16);
    check("bp2_out_bin", 32'(out_bin), 32'd42);
    check("bp2_out_bcd", 32'(out_bcd), 32'd0);
    check("bp2_out_mode", 32'(out_mode), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset during the 4th iteration of 1023
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_bin   = 10'd1023;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_bin", 32'(out_bin), 32'd0);
    check("abort_out_bcd", 32'(out_bcd), 32'd0);
    check("abort_out_mode", 32'(out_mode), 32'd0);
    check("abort_out_err", 32'(out_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_main('{1'b0, 10'd37, 16'h0000, 10'd0, 16'h0037, 1'b0, 10});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
